// File: rtl/vga_timing_gen_if.sv
// Raster bundle between the VGA timing generator and the pixel renderer.
// The generator drives position, decodes and pin outputs; the renderer returns rgbIn.
interface vga_timing_gen_if;
   logic        pixEn;
   logic [9:0]  hCount;
   logic [9:0]  vCount;
   logic        bright;
   logic        lineStart;
   logic        frameStart;
   logic [15:0] frameCount;
   logic [11:0] rgbIn;
   logic [11:0] rgbOut;
   logic        hSync;
   logic        vSync;

   modport master (
      output pixEn, hCount, vCount, bright, lineStart, frameStart, frameCount,
      output rgbOut, hSync, vSync,
      input  rgbIn
   );

   modport slave (
      input  pixEn, hCount, vCount, bright, lineStart, frameStart, frameCount,
      input  rgbOut, hSync, vSync,
      output rgbIn
   );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster generator: pixel-rate strobe, h/v counters, window decodes,
// and a one-pixel-delayed output stage that blanks renderer colour and drives the syncs.
module vga_timing_gen #(
   parameter int CLK_DIV     = 4,
   parameter int H_TOTAL     = 800,
   parameter int H_SYNC      = 96,
   parameter int H_VIS_START = 144,
   parameter int H_VIS_END   = 783,
   parameter int V_TOTAL     = 525,
   parameter int V_SYNC      = 2,
   parameter int V_VIS_START = 35,
   parameter int V_VIS_END   = 514
) (
   input logic              clk,
   input logic              rst_n,
   vga_timing_gen_if.master vga
);
   // A one-bit divider that never leaves zero keeps pixEn tied high when CLK_DIV is 1.
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SYN_C = 10'(H_SYNC);
   localparam logic [9:0] V_SYN_C = 10'(V_SYNC);
   localparam logic [9:0] H_VS_C  = 10'(H_VIS_START);
   localparam logic [9:0] H_VE_C  = 10'(H_VIS_END);
   localparam logic [9:0] V_VS_C  = 10'(V_VIS_START);
   localparam logic [9:0] V_VE_C  = 10'(V_VIS_END);

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       h_q, h_d;
   logic [9:0]       v_q, v_d;
   logic [15:0]      frame_q, frame_d;
   logic [11:0]      rgb_q, rgb_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             pix_en_s;
   logic             bright_s;

   assign pix_en_s = (div_q == DIV_LAST);
   assign bright_s = (h_q >= H_VS_C) && (h_q <= H_VE_C) &&
                     (v_q >= V_VS_C) && (v_q <= V_VE_C);

   // Next-state logic for divider, raster counters and the pin stage.
   always_comb begin
      div_d   = div_q;
      h_d     = h_q;
      v_d     = v_q;
      frame_d = frame_q;
      rgb_d   = rgb_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;

      if (pix_en_s) begin
         div_d = '0;
      end else begin
         div_d = div_q + DIV_W'(1);
      end

      if (pix_en_s) begin
         if (h_q == H_LAST) begin
            h_d = 10'd0;
            if (v_q == V_LAST) begin
               v_d     = 10'd0;
               frame_d = frame_q + 16'd1;
            end else begin
               v_d = v_q + 10'd1;
            end
         end else begin
            h_d = h_q + 10'd1;
         end
         // Pin stage samples the pixel being left, so it trails the counters by one pixel.
         rgb_d   = bright_s ? vga.rgbIn : 12'h000;
         hsync_d = (h_q >= H_SYN_C);
         vsync_d = (v_q >= V_SYN_C);
      end else begin
         h_d = h_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q   <= '0;
         h_q     <= 10'd0;
         v_q     <= 10'd0;
         frame_q <= 16'd0;
         rgb_q   <= 12'h000;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else begin
         div_q   <= div_d;
         h_q     <= h_d;
         v_q     <= v_d;
         frame_q <= frame_d;
         rgb_q   <= rgb_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign vga.pixEn      = pix_en_s;
   assign vga.hCount     = h_q;
   assign vga.vCount     = v_q;
   assign vga.bright     = bright_s;
   assign vga.lineStart  = (h_q == 10'd0);
   assign vga.frameStart = (h_q == 10'd0) && (v_q == 10'd0);
   assign vga.frameCount = frame_q;
   assign vga.rgbOut     = rgb_q;
   assign vga.hSync      = hsync_q;
   assign vga.vSync      = vsync_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a shortened 20x12-pixel raster (CLK_DIV 4) exercises timing, blanking and
// reset; a 1x1 raster with CLK_DIV 1 drives frameCount through its 16-bit wrap.
module tb_vga_timing_gen;
   logic clk;
   logic rst_n;
   logic rst2_n;
   int   checks;
   int   failures;

   vga_timing_gen_if vif();
   vga_timing_gen_if vif2();

   vga_timing_gen #(
      .CLK_DIV(4), .H_TOTAL(20), .H_SYNC(3), .H_VIS_START(5), .H_VIS_END(16),
      .V_TOTAL(12), .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(9)
   ) dut (
      .clk(clk), .rst_n(rst_n), .vga(vif)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_TOTAL(1), .H_SYNC(1), .H_VIS_START(1), .H_VIS_END(1),
      .V_TOTAL(1), .V_SYNC(1), .V_VIS_START(1), .V_VIS_END(1)
   ) dut_wrap (
      .clk(clk), .rst_n(rst2_n), .vga(vif2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int          strobes, hs_low, vs_low, bright_tot, ls_rises, fs_rises;
   int          last_ls, last_fs, fc1_at, fc2_at, first_rgb_h, first_rgb_v;
   int          bright_line [12];
   int          ediv;
   logic        prev_ls, prev_fs, ebright, ehs, evs, found;
   logic [15:0] prev_fc, ef;
   logic [9:0]  eh, ev;
   logic [11:0] ergb;

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      rst2_n = 1'b0;
      vif.rgbIn = 12'hFFF;
      vif2.rgbIn = 12'h000;

      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("rst_hSync", 32'(vif.hSync), 32'd1);
         chk("rst_vSync", 32'(vif.vSync), 32'd1);
         chk("rst_rgbOut", 32'(vif.rgbOut), 32'h000);
      end
      chk("rst_hCount", 32'(vif.hCount), 32'd0);
      chk("rst_vCount", 32'(vif.vCount), 32'd0);
      chk("rst_frameCount", 32'(vif.frameCount), 32'd0);
      chk("rst_bright", 32'(vif.bright), 32'd0);
      chk("rst_lineStart", 32'(vif.lineStart), 32'd1);
      chk("rst_frameStart", 32'(vif.frameStart), 32'd1);
      chk("rst_pixEn", 32'(vif.pixEn), 32'd0);

      rst_n = 1'b1;
      @(negedge clk);
      chk("rel1_pixEn", 32'(vif.pixEn), 32'd0);
      @(negedge clk);
      chk("rel2_pixEn", 32'(vif.pixEn), 32'd0);
      @(negedge clk);
      chk("rel3_pixEn", 32'(vif.pixEn), 32'd1);
      chk("rel3_hCount", 32'(vif.hCount), 32'd0);
      @(negedge clk);
      chk("rel4_pixEn", 32'(vif.pixEn), 32'd0);
      chk("rel4_hCount", 32'(vif.hCount), 32'd1);
      chk("rel4_hSync", 32'(vif.hSync), 32'd0);
      chk("rel4_vSync", 32'(vif.vSync), 32'd0);

      // Two full frames starting from pixel (1,0), checked on every clock.
      strobes = 0; hs_low = 0; vs_low = 0; bright_tot = 0; ls_rises = 0; fs_rises = 0;
      last_ls = -1; last_fs = -1; fc1_at = -1; fc2_at = -1; first_rgb_h = -1; first_rgb_v = -1;
      for (int k = 0; k < 12; k++) bright_line[k] = 0;
      ediv = 0; eh = 10'd1; ev = 10'd0; ef = 16'd0; ergb = 12'h000; ehs = 1'b0; evs = 1'b0;
      prev_ls = 1'b0; prev_fs = 1'b0; prev_fc = 16'd0;
      for (int i = 0; i < 1920; i++) begin
         vif.rgbIn = (ef == 16'd0) ? 12'hFFF : 12'h5A3;
         ebright = (eh >= 10'd5) && (eh <= 10'd16) && (ev >= 10'd3) && (ev <= 10'd9);
         chk("run_pixEn", 32'(vif.pixEn), 32'(ediv == 3));
         chk("run_hCount", 32'(vif.hCount), 32'(eh));
         chk("run_vCount", 32'(vif.vCount), 32'(ev));
         chk("run_frameCount", 32'(vif.frameCount), 32'(ef));
         chk("run_bright", 32'(vif.bright), 32'(ebright));
         chk("run_lineStart", 32'(vif.lineStart), 32'(eh == 10'd0));
         chk("run_frameStart", 32'(vif.frameStart), 32'(eh == 10'd0 && ev == 10'd0));
         chk("run_rgbOut", 32'(vif.rgbOut), 32'(ergb));
         chk("run_hSync", 32'(vif.hSync), 32'(ehs));
         chk("run_vSync", 32'(vif.vSync), 32'(evs));
         if (vif.lineStart && !prev_ls) begin
            if (last_ls >= 0) chk("lineStart_gap", 32'(i - last_ls), 32'd80);
            last_ls = i;
            ls_rises++;
         end
         if (vif.frameStart && !prev_fs) begin
            if (last_fs >= 0) chk("frameStart_gap", 32'(i - last_fs), 32'd960);
            last_fs = i;
            fs_rises++;
         end
         if (vif.frameCount != prev_fc) begin
            if (vif.frameCount == 16'd1) fc1_at = i;
            if (vif.frameCount == 16'd2) fc2_at = i;
         end
         if (first_rgb_h < 0 && vif.rgbOut != 12'h000) begin
            first_rgb_h = int'(vif.hCount);
            first_rgb_v = int'(vif.vCount);
         end
         if (ediv == 3) begin
            strobes++;
            if (vif.bright) begin
               bright_line[ev]++;
               bright_tot++;
            end
            if (!vif.hSync) hs_low++;
            if (!vif.vSync) vs_low++;
            ergb = ebright ? vif.rgbIn : 12'h000;
            ehs = (eh >= 10'd3);
            evs = (ev >= 10'd2);
            if (eh == 10'd19) begin
               eh = 10'd0;
               if (ev == 10'd11) begin
                  ev = 10'd0;
                  ef = ef + 16'd1;
               end else begin
                  ev = ev + 10'd1;
               end
            end else begin
               eh = eh + 10'd1;
            end
         end
         ediv = (ediv + 1) % 4;
         prev_ls = vif.lineStart;
         prev_fs = vif.frameStart;
         prev_fc = vif.frameCount;
         @(negedge clk);
      end
      chk("sum_strobes", 32'(strobes), 32'd480);
      chk("sum_bright_line3", 32'(bright_line[3]), 32'd24);
      chk("sum_bright_line2", 32'(bright_line[2]), 32'd0);
      chk("sum_bright_line9", 32'(bright_line[9]), 32'd24);
      chk("sum_bright_line10", 32'(bright_line[10]), 32'd0);
      chk("sum_bright_total", 32'(bright_tot), 32'd168);
      chk("sum_hSync_low", 32'(hs_low), 32'd72);
      chk("sum_vSync_low", 32'(vs_low), 32'd80);
      chk("sum_lineStart_rises", 32'(ls_rises), 32'd24);
      chk("sum_frameStart_rises", 32'(fs_rises), 32'd2);
      chk("frameCount1_at", 32'(fc1_at), 32'd956);
      chk("frameCount2_at", 32'(fc2_at), 32'd1916);
      chk("first_rgb_h", 32'(first_rgb_h), 32'd6);
      chk("first_rgb_v", 32'(first_rgb_v), 32'd3);
      chk("end_hCount", 32'(vif.hCount), 32'd1);
      chk("end_vCount", 32'(vif.vCount), 32'd0);
      chk("end_frameCount", 32'(vif.frameCount), 32'd2);

      // Reset in the middle of a visible line.
      vif.rgbIn = 12'hAAA;
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         if (vif.hCount == 10'd10 && vif.vCount == 10'd6) found = 1'b1;
         else @(negedge clk);
      end
      chk("mid_reached", 32'(found), 32'd1);
      chk("mid_rgbOut_before", 32'(vif.rgbOut), 32'hAAA);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_hCount", 32'(vif.hCount), 32'd0);
      chk("mid_vCount", 32'(vif.vCount), 32'd0);
      chk("mid_frameCount", 32'(vif.frameCount), 32'd0);
      chk("mid_rgbOut", 32'(vif.rgbOut), 32'h000);
      chk("mid_hSync", 32'(vif.hSync), 32'd1);
      chk("mid_vSync", 32'(vif.vSync), 32'd1);
      chk("mid_pixEn", 32'(vif.pixEn), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("mid_rel3_pixEn", 32'(vif.pixEn), 32'd1);
      @(negedge clk);
      chk("mid_rel4_hCount", 32'(vif.hCount), 32'd1);
      chk("mid_rel4_vCount", 32'(vif.vCount), 32'd0);

      // 1x1 raster: every clock completes a frame.
      rst2_n = 1'b1;
      for (int k = 0; k < 65535; k++) @(negedge clk);
      chk("wrap_pixEn", 32'(vif2.pixEn), 32'd1);
      chk("wrap_pre", 32'(vif2.frameCount), 32'hFFFF);
      @(negedge clk);
      chk("wrap_zero", 32'(vif2.frameCount), 32'h0000);
      @(negedge clk);
      chk("wrap_one", 32'(vif2.frameCount), 32'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
